// File: rtl/uart_byte_rx_sampler_if.sv
// Byte-delivery bus of the UART receive sampler: received byte, completion and
// framing-error strobes, and the receiver busy flag.
interface uart_byte_rx_sampler_if;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       busy;

    modport master (
        output data,
        output done,
        output frame_err,
        output busy
    );

    modport slave (
        input data,
        input done,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_byte_rx_sampler.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit glitch rejection,
// mid-bit sampling, framing-error detection, one-cycle done/frame_err strobes.
module uart_byte_rx_sampler #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    uart_byte_rx_sampler_if.master  byte_bus
);

    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CPB - 1) / 2);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_byte_rx_sampler: CLK_FREQ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift, shift_d;
    logic [7:0]       data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       sync_q;
    logic             rx_s;

    // Synchroniser flops reset to 1 so an idle line is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is no longer low at its centre was a glitch.
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_d[bit_idx] = rx_s;
                    cnt_d            = '0;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            // Returning to IDLE at the stop-bit centre leaves half a bit of margin
            // for a back-to-back start bit.
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_bus.data      = data_q;
    assign byte_bus.done      = done_q;
    assign byte_bus.frame_err = err_q;
    assign byte_bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx_sampler.sv
// Directed self-checking bench for uart_byte_rx_sampler at CPB=16.
module tb_uart_byte_rx_sampler;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + (CPB - 1) / 2 + 1 + 9 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;

    uart_byte_rx_sampler_if bus ();

    uart_byte_rx_sampler #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_bus (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stab_err = 0;
    int both_err = 0;
    int repeat_err = 0;
    logic [7:0] last_data = 8'h00;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records strobes and flags protocol violations between checks.
    always @(negedge clk) begin
        if (reset) begin
            last_data = bus.data;
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                got_q.push_back(bus.data);
                last_data = bus.data;
            end else if (bus.data !== last_data) begin
                stab_err++;
            end
            if (bus.frame_err) err_cnt++;
            if (bus.done && bus.frame_err) both_err++;
            if ((bus.done && prev_done) || (bus.frame_err && prev_err)) repeat_err++;
            prev_done = bus.done;
            prev_err  = bus.frame_err;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame, optionally truncated after max_cycles clocks.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int max_cycles);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10 * CPB && i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) start_cyc = cyc + 1;
            rx = frame[i / CPB];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int e0;
        int lat;
        int waited;
        logic [7:0] exp_b2b [4];
        exp_b2b = '{8'h01, 8'h3C, 8'h02, 8'hFF};

        reset = 1'b1;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_data", {24'h0, bus.data}, 32'h00);
        checkOutput("rst_done", {31'h0, bus.done}, 32'h0);
        checkOutput("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        checkOutput("rst_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);

        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(8'hA5, 1'b1, 10 * CPB);
        idle(20);
        lat = done_cyc - start_cyc;
        checkOutput("a5_count", done_cnt - d0, 1);
        checkOutput("a5_data", {24'h0, bus.data}, 32'hA5);
        // Allow the one-cycle edge-alignment tolerance on latency.
        checkOutput("a5_latency", (lat >= LATENCY - 1 && lat <= LATENCY + 1) ? LATENCY : lat, LATENCY);
        checkOutput("a5_ferr", err_cnt - e0, 0);

        d0 = done_cnt;
        got_q.delete();
        for (int k = 0; k < 4; k++) applyStimulus(exp_b2b[k], 1'b1, 10 * CPB);
        idle(20);
        checkOutput("b2b_count", done_cnt - d0, 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("b2b_data%0d", k),
                        (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hDEAD, {24'h0, exp_b2b[k]});
        end
        checkOutput("b2b_ferr", err_cnt - e0, 0);

        d0 = done_cnt;
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        waited = 0;
        while (bus.busy && waited < 12) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("glitch_busy", {31'h0, bus.busy}, 32'h0);
        idle(10);
        checkOutput("glitch_done", done_cnt - d0, 0);
        applyStimulus(8'h5A, 1'b1, 10 * CPB);
        idle(20);
        checkOutput("post_glitch_count", done_cnt - d0, 1);
        checkOutput("post_glitch_data", {24'h0, bus.data}, 32'h5A);

        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(8'hC3, 1'b0, 10 * CPB);
        idle(40);
        checkOutput("ferr_count", err_cnt - e0, 1);
        checkOutput("ferr_data_kept", {24'h0, bus.data}, 32'h5A);
        checkOutput("ferr_busy_held", {31'h0, bus.busy}, 32'h1);
        checkOutput("ferr_no_done", done_cnt - d0, 0);
        rx = 1'b1;
        idle(10);
        checkOutput("break_exit_busy", {31'h0, bus.busy}, 32'h0);
        checkOutput("break_no_retrigger", err_cnt - e0, 1);
        applyStimulus(8'h04, 1'b1, 10 * CPB);
        idle(20);
        checkOutput("after_break_count", done_cnt - d0, 1);
        checkOutput("after_break_data", {24'h0, bus.data}, 32'h04);

        d0 = done_cnt;
        e0 = err_cnt;
        applyStimulus(8'h77, 1'b1, 5 * CPB + CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        idle(3);
        @(negedge clk);
        checkOutput("midrst_data", {24'h0, bus.data}, 32'h00);
        checkOutput("midrst_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(200);
        checkOutput("midrst_no_done", done_cnt - d0, 0);
        checkOutput("midrst_no_ferr", err_cnt - e0, 0);
        applyStimulus(8'h77, 1'b1, 10 * CPB);
        idle(20);
        checkOutput("resend_count", done_cnt - d0, 1);
        checkOutput("resend_data", {24'h0, bus.data}, 32'h77);

        checkOutput("data_stability", stab_err, 0);
        checkOutput("done_ferr_exclusive", both_err, 0);
        checkOutput("strobe_single_cycle", repeat_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
